// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment table is active-high, bit order {g,f,e,d,c,b,a}.
package sevseg_pkg;

    typedef enum logic {
        S_BLANK,
        S_ON
    } state_e;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sevseg_if.sv
// Datapath-facing bundle of the seven-segment scan driver.
// master = datapath side, slave = driver side.
interface sevseg_if #(
    parameter int NUM_DIGITS = 2
) ();

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic                    update_i;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic [IW-1:0]           digit_idx_o;
    logic                    frame_done_o;

    modport master (
        output digits_i, dp_i, blank_i, update_i,
        input  seg_o, dp_o, an_o, digit_idx_o, frame_done_o
    );

    modport slave (
        input  digits_i, dp_i, blank_i, update_i,
        output seg_o, dp_o, an_o, digit_idx_o, frame_done_o
    );

endinterface

// File: rtl/sevseg_decode.sv
// Hex nibble to active-high seven-segment pattern.
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/sevseg_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver with dead time
// and a frame-synchronous shadow register.
module sevseg_mux_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int REFRESH_DIV    = 20000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic clk,
    input logic reset,
    sevseg_if.slave bus
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    state_e        st_q, st_d;
    logic          pend_q, pend_d;

    logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]      blk_q, blk_d;

    logic [6:0]            seg_q, seg_d;
    logic                  dpo_q, dpo_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;

    logic [3:0] nib;
    logic [6:0] seg_hi;
    logic       load;
    logic       on;

    sevseg_decode u_dec (
        .nib_i (nib),
        .seg_o (seg_hi)
    );

    // Outputs are built from next-state values so they line up with cnt/state.
    always_comb begin
        load   = fd_q & (pend_q | bus.update_i);
        pend_d = ~load & (pend_q | bus.update_i);
        dig_d  = load ? bus.digits_i : dig_q;
        dp_d   = load ? bus.dp_i : dp_q;
        blk_d  = load ? bus.blank_i : blk_q;

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        st_d = (int'(cnt_d) < BLANK_CYCLES) ? S_BLANK : S_ON;

        nib   = dig_d[idx_d];
        on    = (st_d == S_ON) & ~blk_d[idx_d];
        an_d  = {NUM_DIGITS{AN_ACTIVE_LOW}}
              ^ (on ? (NUM_DIGITS'(1) << idx_d) : '0);
        seg_d = {7{SEG_ACTIVE_LOW}} ^ (on ? seg_hi : 7'h00);
        dpo_d = SEG_ACTIVE_LOW ^ (on & dp_d[idx_d]);
        fd_d  = (cnt_d == CNT_MAX) & (idx_d == IDX_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            st_q   <= S_BLANK;
            pend_q <= 1'b0;
            dig_q  <= '0;
            dp_q   <= '0;
            blk_q  <= '0;
            seg_q  <= {7{SEG_ACTIVE_LOW}};
            dpo_q  <= SEG_ACTIVE_LOW;
            an_q   <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            st_q   <= st_d;
            pend_q <= pend_d;
            dig_q  <= dig_d;
            dp_q   <= dp_d;
            blk_q  <= blk_d;
            seg_q  <= seg_d;
            dpo_q  <= dpo_d;
            an_q   <= an_d;
            fd_q   <= fd_d;
        end
    end

    assign bus.seg_o        = seg_q;
    assign bus.dp_o         = dpo_q;
    assign bus.an_o         = an_q;
    assign bus.digit_idx_o  = idx_q;
    assign bus.frame_done_o = fd_q;

endmodule

// File: doc/sevseg_mux_driver.md
Name: sevseg_mux_driver

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display. It scans NUM_DIGITS hex digits onto one shared segment bus, one digit per time slot. A dead-time gap between slots suppresses ghosting. Display contents come from a shadow register that loads only at frame boundaries, so digits never tear. The block sits between datapath logic (counters, switch inputs) and the FPGA display pins.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (legal 1..8)
REFRESH_DIV, 20000, clk cycles per digit slot (must exceed BLANK_CYCLES)
BLANK_CYCLES, 16, cycles at slot start with all anodes off (legal 0..REFRESH_DIV-1)
SEG_ACTIVE_LOW, 1, 1 = seg_o/dp_o lit when 0
AN_ACTIVE_LOW, 1, 1 = an_o digit enabled when 0

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
digits_i  input  4*NUM_DIGITS  hex nibbles; nibble k = digits_i[4k+3:4k] drives digit k
dp_i  input  NUM_DIGITS  decimal point request per digit
blank_i  input  NUM_DIGITS  1 = digit k forced dark
update_i  input  1  request to load digits_i/dp_i/blank_i into the shadow register
seg_o  output  7  segments, bit order {g,f,e,d,c,b,a} (seg_o[0]=a)
dp_o  output  1  decimal point
an_o  output  NUM_DIGITS  anode enables, an_o[k] = digit k
digit_idx_o  output  $clog2(NUM_DIGITS) (min 1)  digit slot currently being scanned
frame_done_o  output  1  one-cycle pulse in the last cycle of slot NUM_DIGITS-1

Behaviour:
- Reset values:
  - an_o all inactive; seg_o all unlit; dp_o unlit.
  - digit_idx_o = 0; frame_done_o = 0.
  - Shadow register = 0; pending flag = 0; slot counter = 0; state = S_BLANK.
- Slot counter cnt runs 0..REFRESH_DIV-1, then wraps. digit_idx_o advances on the wrap. It wraps from NUM_DIGITS-1 back to 0.
- FSM, two states:
  - S_BLANK while cnt < BLANK_CYCLES.
  - S_ON while BLANK_CYCLES <= cnt <= REFRESH_DIV-1.
  - BLANK_CYCLES = 0 means no S_BLANK state; the slot is entirely S_ON.
- All outputs are registered and change on the same edge as the state/cnt they describe. There is no extra pipeline lag.
- In S_ON for slot k:
  - If shadow blank[k] = 0: an_o[k] active, all other anodes inactive; seg_o = decode(shadow nibble k); dp_o = shadow dp[k].
  - If shadow blank[k] = 1: all anodes inactive and segments unlit.
- In S_BLANK: all anodes inactive; seg_o and dp_o unlit.
- Hex decode, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Invert when SEG_ACTIVE_LOW = 1.
- Update handling:
  - update_i = 1 in any cycle sets the pending flag. The values are sampled at load time, not at request time.
  - The shadow loads from the live inputs on the edge ending the frame_done_o cycle, if pending is set or update_i = 1 in that cycle. Pending clears on that edge.
  - Repeated requests within one frame collapse into one load.
- NUM_DIGITS = 1: digit_idx_o stays 0; frame_done_o pulses every slot.
- Reset mid-operation wins over everything. The next edge restores all reset values and scanning restarts at slot 0 in S_BLANK.

Decomposition:
- Package sevseg_pkg holds:
  - the 16-entry hex-to-segment constant table, active-high;
  - the segment bit-index constants SEG_A..SEG_G;
  - an enum type for the states S_BLANK and S_ON.
- One combinational sub-module, sevseg_decode (4-bit nibble in, 7-bit active-high segments out), instantiated once on the muxed nibble.
- Polarity inversion happens in the top block.

Test Plan:
Bench parameters: NUM_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2, both polarities active-low. Frame = 16 cycles.
1. Reset held 3 cycles -> an_o=2'b11, seg_o=7'h7F, dp_o=1, digit_idx_o=0, frame_done_o=0 on every cycle.
2. digits_i=8'h3A, dp_i=2'b10, update_i pulse in cycle 1, then one full frame -> slot 0 shows an_o=2'b10, seg_o=7'h08 (A), dp_o=1; slot 1 shows an_o=2'b01, seg_o=7'h30 (3), dp_o=0.
3. Dead time: for each slot, an_o=2'b11 for exactly cycles cnt 0-1 and one digit active for cnt 2-7 -> frame_done_o pulses exactly every 16 cycles, in cnt=7 of slot 1.
4. Tear-free update: while showing 8'h3A, drive digits_i=8'h5E without update_i -> display unchanged. Pulse update_i at cnt=3 of slot 0 -> 3A kept to the end of the frame; next frame shows digit0=E (7'h06), digit1=5 (7'h12).
5. blank_i=2'b10 with update -> an_o[1] never goes low and seg_o=7'h7F throughout slot 1; slot 0 unaffected.
6. Reset asserted at cnt=4 of slot 1 -> next edge gives reset values and a cleared shadow. After release: digit_idx_o=0, an_o=2'b11 for 2 cycles, then digit 0 shows 0 (7'h40).
